// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter:
// FSM state codes, frame constants and the parity helper.
package ps2_pkg;

  localparam int   FRAME_BITS   = 11;
  localparam logic PS2_IDLE_LVL = 1'b1;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t S_IDLE    = 2'd0;
  localparam ps2_state_t S_SEND    = 2'd1;
  localparam ps2_state_t S_GAP     = 2'd2;
  localparam ps2_state_t S_INHIBIT = 2'd3;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scancode byte stream into the PS/2 transmitter:
// valid/ready handshake, producer is master.
interface ps2_kbd_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ps2_tx_fifo.sv
// Scancode queue: head is peeked while a frame is sent
// and popped only when the frame completes.
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rd];
  // A full queue refuses writes even if it drains this cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter, 11-bit frames.
// Optional PS2_TX_PARITY_INJ_EN adds err_inject parity flip.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_GAP   = 2
) (
  input  logic        clk,
  input  logic        clrn,
  ps2_kbd_tx_if.slave s_if,
  input  logic        host_inhibit,
`ifdef PS2_TX_PARITY_INJ_EN
  input  logic        err_inject,
`endif
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy
);

  localparam int GAP_CYC = IDLE_GAP * 2 * CLK_DIV;
  localparam int CW      = $clog2(CLK_DIV);
  localparam int GW      = $clog2(GAP_CYC);

  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0]    PAR_BIT  = 4'(FRAME_BITS - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  // GAP is one short: the IDLE cycle completes the high time.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 2);

  ps2_state_t    r_state;
  logic [3:0]    r_bit;
  logic          r_hi;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic          r_inj;
  logic          r_ps2_clk;
  logic          r_ps2_data;
  logic          r_busy;

  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic          w_pop;
  logic          w_last;
  logic          w_abort;
  logic          w_start;
  logic          w_drive;
  logic          w_bit;
  logic [2:0]    w_idx;
  logic          w_inj;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (s_if.in_valid),
    .wdata (s_if.in_data),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign s_if.in_ready = !w_full;
  assign ps2_clk       = r_ps2_clk;
  assign ps2_data      = r_ps2_data;
  assign busy          = r_busy;

`ifdef PS2_TX_PARITY_INJ_EN
  assign w_inj = err_inject;
`else
  assign w_inj = 1'b0;
`endif

  assign w_last  = (r_cnt == CNT_LAST);
  assign w_abort = (r_state == S_SEND) && (r_bit <= PAR_BIT)
                && host_inhibit;
  assign w_start = (r_state == S_IDLE) && !w_empty
                && !host_inhibit;
  assign w_pop   = (r_state == S_SEND) && (r_bit == LAST_BIT)
                && !r_hi && w_last;
  assign w_drive = (r_state == S_SEND) && !w_abort;
  assign w_idx   = 3'(r_bit - 4'd1);

  always_comb begin
    w_bit = PS2_IDLE_LVL;
    unique case (1'b1)
      (r_bit == 4'd0):
        w_bit = 1'b0;
      (r_bit != 4'd0 && r_bit < PAR_BIT):
        w_bit = w_head[w_idx];
      (r_bit == PAR_BIT):
        w_bit = odd_parity(w_head) ^ r_inj;
      default:
        w_bit = PS2_IDLE_LVL;
    endcase
  end

  // Line registers lag the FSM by one cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_hi       <= 1'b1;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_inj      <= 1'b0;
      r_ps2_clk  <= PS2_IDLE_LVL;
      r_ps2_data <= PS2_IDLE_LVL;
      r_busy     <= 1'b0;
    end else begin
      r_ps2_clk  <= w_drive ? r_hi : PS2_IDLE_LVL;
      r_ps2_data <= w_drive ? w_bit : PS2_IDLE_LVL;
      r_busy     <= (r_state != S_IDLE) || !w_empty;
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_start) begin
            r_state <= S_SEND;
            r_bit   <= '0;
            r_hi    <= 1'b1;
            r_cnt   <= '0;
            r_inj   <= w_inj;
          end
        end
        (r_state == S_SEND): begin
          if (w_abort) begin
            r_state <= S_INHIBIT;
          end else if (!w_last) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            r_hi  <= !r_hi;
            if (!r_hi) begin
              if (r_bit == LAST_BIT) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end
        end
        (r_state == S_GAP): begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else                   r_gap   <= r_gap + GW'(1);
        end
        (r_state == S_INHIBIT): begin
          if (!host_inhibit) begin
            r_state <= S_GAP;
            r_gap   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx (CLK_DIV=4, depth 8, 32-cycle gap).
// Frames are decoded from the lines at each falling ps2_clk.
module tb_ps2_kbd_tx;

  logic clk = 1'b0;
  logic clrn;
  logic host_inhibit;
  logic err_inject;
  logic ps2_clk;
  logic ps2_data;
  logic busy;

  int vec  = 0;
  int miss = 0;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (8),
    .IDLE_GAP   (4)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .s_if         (bus),
    .host_inhibit (host_inhibit),
`ifdef PS2_TX_PARITY_INJ_EN
    .err_inject   (err_inject),
`endif
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // line monitor
  logic [10:0] frames_q[$];
  int          len_q[$];
  int          gap_q[$];
  logic [10:0] m_buf = '0;
  logic [3:0]  m_bits = '0;
  logic        m_in = 1'b0;
  logic        m_pclk = 1'b1;
  logic        m_pdat = 1'b1;
  int          m_len = 0;
  int          m_run = 0;

  always @(negedge clk) begin
    if (ps2_clk && !ps2_data && m_pclk && m_pdat) begin
      gap_q.push_back(m_run);
      m_in   = 1'b1;
      m_bits = '0;
      m_len  = 1;
    end else if (m_in) begin
      if (m_bits == 4'd11 && ps2_clk) begin
        frames_q.push_back(m_buf);
        len_q.push_back(m_len);
        m_in = 1'b0;
      end else begin
        m_len++;
        if (m_pclk && !ps2_clk && m_bits < 4'd11) begin
          m_buf[m_bits] = ps2_data;
          m_bits++;
        end
      end
    end
    m_run  = (ps2_clk && ps2_data) ? m_run + 1 : 0;
    m_pclk = ps2_clk;
    m_pdat = ps2_data;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    frames_q.delete();
    len_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy !== 1'b0 || ps2_clk !== 1'b1 || ps2_data !== 1'b1)
           && n < 3000) begin
      tick();
      n++;
    end
    vec++;
    if (n >= 3000) begin
      miss++;
      $display("FAIL idle_timeout got busy=%b want 0", busy);
    end
    repeat (5) tick();
  endtask

  task automatic wait_frames(input int k, input int bound);
    int n = 0;
    while (frames_q.size() < k && n < bound) begin
      tick();
      n++;
    end
    vec++;
    if (frames_q.size() < k) begin
      miss++;
      $display("FAIL frame_timeout got %0d frames want %0d",
               frames_q.size(), k);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    repeat (3) tick();
    vec++;
    if (ps2_clk !== 1'b1) begin
      miss++; $display("FAIL rst_clk got %b want 1", ps2_clk);
    end
    vec++;
    if (ps2_data !== 1'b1) begin
      miss++; $display("FAIL rst_data got %b want 1", ps2_data);
    end
    vec++;
    if (busy !== 1'b0) begin
      miss++; $display("FAIL rst_busy got %b want 0", busy);
    end
    vec++;
    if (bus.in_ready !== 1'b1) begin
      miss++; $display("FAIL rst_ready got %b want 1", bus.in_ready);
    end
    clrn = 1'b1;
    repeat (10) tick();
    vec++;
    if (busy !== 1'b0 || ps2_clk !== 1'b1) begin
      miss++;
      $display("FAIL post_rst got busy=%b clk=%b want 0/1",
               busy, ps2_clk);
    end
  endtask

  task automatic test_single;
    int n;
    wait_idle();
    clear_mon();
    push1(8'h1C);
    tick();
    vec++;
    if (ps2_data !== 1'b1) begin
      miss++; $display("FAIL lat_e1 got %b want 1", ps2_data);
    end
    tick();
    vec++;
    if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin
      miss++;
      $display("FAIL lat_e2 got data=%b clk=%b want 0/1",
               ps2_data, ps2_clk);
    end
    wait_frames(1, 300);
    if (frames_q.size() > 0) begin
      vec++;
      if (frames_q[0] !== 11'h438) begin
        miss++;
        $display("FAIL frame_1c got %h want 438", frames_q[0]);
      end
      vec++;
      if (len_q[0] != 88) begin
        miss++; $display("FAIL len_1c got %0d want 88", len_q[0]);
      end
      n = 1;
      while (busy !== 1'b0 && n < 100) begin
        tick();
        n++;
      end
      vec++;
      if (n != 32) begin
        miss++; $display("FAIL busy_drop got %0d want 32", n);
      end
    end
  endtask

  task automatic test_back_to_back;
    wait_idle();
    clear_mon();
    bus.in_data  = 8'hF0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data  = 8'h1C;
    tick();
    bus.in_valid = 1'b0;
    wait_frames(2, 600);
    if (frames_q.size() >= 2) begin
      vec++;
      if (frames_q[0] !== 11'h7E0) begin
        miss++;
        $display("FAIL b2b_f0 got %h want 7e0", frames_q[0]);
      end
      vec++;
      if (frames_q[1] !== 11'h438) begin
        miss++;
        $display("FAIL b2b_1c got %h want 438", frames_q[1]);
      end
      vec++;
      if (gap_q.size() < 2 || gap_q[1] != 32) begin
        miss++;
        $display("FAIL b2b_gap got %0d want 32",
                 gap_q.size() < 2 ? -1 : gap_q[1]);
      end
      vec++;
      if (len_q[1] != 88) begin
        miss++; $display("FAIL b2b_len got %0d want 88", len_q[1]);
      end
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] b [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                         8'h2B, 8'h34, 8'h33, 8'hE0};
    int n = 0;
    wait_idle();
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      bus.in_data  = b[i];
      bus.in_valid = 1'b1;
      tick();
    end
    vec++;
    if (bus.in_ready !== 1'b0) begin
      miss++; $display("FAIL full_ready got %b want 0", bus.in_ready);
    end
    bus.in_data = b[8];
    while (bus.in_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    vec++;
    if (n >= 500 || frames_q.size() != 0) begin
      miss++;
      $display("FAIL pre_pop got %0d frames want 0",
               frames_q.size());
    end
    tick();
    bus.in_valid = 1'b0;
    vec++;
    if (frames_q.size() != 1) begin
      miss++;
      $display("FAIL pop_accept got %0d frames want 1",
               frames_q.size());
    end
    wait_frames(9, 2000);
    for (int i = 0; i < 9; i++) begin
      if (i < frames_q.size()) begin
        vec++;
        if (frames_q[i] !== exp_frame(b[i])) begin
          miss++;
          $display("FAIL fifo_frame%0d got %h want %h",
                   i, frames_q[i], exp_frame(b[i]));
        end
      end
    end
  endtask

  task automatic test_inhibit;
    int n = 0;
    int bad = 0;
    wait_idle();
    clear_mon();
    push1(8'h1C);
    while (!(m_bits == 4'd6 && ps2_clk == 1'b0) && n < 300) begin
      tick();
      n++;
    end
    host_inhibit = 1'b1;
    tick();
    vec++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      miss++;
      $display("FAIL abort_lines got clk=%b data=%b want 1/1",
               ps2_clk, ps2_data);
    end
    for (int i = 0; i < 99; i++) begin
      tick();
      if (!ps2_clk || !ps2_data || !busy) bad++;
    end
    vec++;
    if (bad != 0) begin
      miss++; $display("FAIL inh_hold got %0d bad cycles want 0", bad);
    end
    host_inhibit = 1'b0;
    n = 0;
    while (!(ps2_clk && !ps2_data) && n < 200) begin
      tick();
      n++;
    end
    // gap plus the INHIBIT exit and output register cycles
    vec++;
    if (n < 32 || n > 34) begin
      miss++; $display("FAIL inh_gap got %0d want 32..34", n);
    end
    wait_frames(1, 200);
    if (frames_q.size() > 0) begin
      vec++;
      if (frames_q[0] !== 11'h438) begin
        miss++;
        $display("FAIL inh_frame got %h want 438", frames_q[0]);
      end
    end
    wait_idle();
    repeat (100) tick();
    vec++;
    if (frames_q.size() != 1) begin
      miss++;
      $display("FAIL inh_once got %0d frames want 1",
               frames_q.size());
    end
  endtask

`ifdef PS2_TX_PARITY_INJ_EN
  task automatic test_parity_inj;
    wait_idle();
    clear_mon();
    err_inject = 1'b1;
    push1(8'h1C);
    wait_frames(1, 300);
    err_inject = 1'b0;
    if (frames_q.size() > 0) begin
      vec++;
      if (frames_q[0] !== 11'h638) begin
        miss++;
        $display("FAIL inj_on got %h want 638", frames_q[0]);
      end
    end
    wait_idle();
    clear_mon();
    push1(8'h1C);
    wait_frames(1, 300);
    if (frames_q.size() > 0) begin
      vec++;
      if (frames_q[0] !== 11'h438) begin
        miss++;
        $display("FAIL inj_off got %h want 438", frames_q[0]);
      end
    end
  endtask
`endif

  task automatic test_mid_reset;
    int n = 0;
    wait_idle();
    clear_mon();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h1C;
    tick();
    bus.in_data  = 8'h32;
    tick();
    bus.in_data  = 8'h21;
    tick();
    bus.in_valid = 1'b0;
    while (!(m_bits == 4'd7 && ps2_clk == 1'b0) && n < 300) begin
      tick();
      n++;
    end
    clrn = 1'b0;
    #1;
    vec++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      miss++;
      $display("FAIL mrst_lines got clk=%b data=%b want 1/1",
               ps2_clk, ps2_data);
    end
    vec++;
    if (busy !== 1'b0) begin
      miss++; $display("FAIL mrst_busy got %b want 0", busy);
    end
    vec++;
    if (bus.in_ready !== 1'b1) begin
      miss++; $display("FAIL mrst_ready got %b want 1", bus.in_ready);
    end
    tick();
    tick();
    clrn = 1'b1;
    clear_mon();
    repeat (300) tick();
    vec++;
    if (gap_q.size() != 0) begin
      miss++;
      $display("FAIL mrst_noframe got %0d starts want 0",
               gap_q.size());
    end
    vec++;
    if (busy !== 1'b0) begin
      miss++; $display("FAIL mrst_idle got %b want 0", busy);
    end
  endtask

  initial begin
    clrn         = 1'b0;
    host_inhibit = 1'b0;
    err_inject   = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_inhibit();
`ifdef PS2_TX_PARITY_INJ_EN
    test_parity_inj();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
